// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus iterative one-bit-per-cycle
// shifts, with a registered result and a valid/ready handshake on both sides.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic                 zero_q, zero_d;
  logic [XLEN-1:0]      shiftReg_q, shiftReg_d;
  logic [SHAMT_W-1:0]   count_q, count_d;
  logic [3:0]           op_q, op_d;
  logic                 inReady_q, outValid_q, busy_q;

  logic [XLEN-1:0]      aluRes;
  logic [XLEN-1:0]      shifted;
  logic                 isShift;
  logic [SHAMT_W-1:0]   shamt;

  assign isShift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign shamt   = operand_b[SHAMT_W-1:0];

  always_comb begin
    aluRes = '0;
    case (alu_ctrl)
      OP_AND:  aluRes = operand_a & operand_b;
      OP_OR:   aluRes = operand_a | operand_b;
      OP_ADD:  aluRes = operand_a + operand_b;
      OP_SUB:  aluRes = operand_a - operand_b;
      OP_XOR:  aluRes = operand_a ^ operand_b;
      OP_SLT:  aluRes = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      default: aluRes = '0;
    endcase
  end

  // Repeated 1-bit arithmetic right shifts keep replicating the original sign bit.
  always_comb begin
    case (op_q)
      OP_SLL:  shifted = {shiftReg_q[XLEN-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, shiftReg_q[XLEN-1:1]};
      default: shifted = {shiftReg_q[XLEN-1], shiftReg_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    shiftReg_d = shiftReg_q;
    count_d    = count_q;
    op_d       = op_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (isShift) begin
            op_d       = alu_ctrl;
            shiftReg_d = operand_a;
            count_d    = shamt;
            if (shamt == '0) begin
              result_d = operand_a;
              zero_d   = (operand_a == '0);
              state_d  = S_DONE;
            end else begin
              state_d  = S_SHIFT;
            end
          end else begin
            result_d = aluRes;
            zero_d   = (aluRes == '0);
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        shiftReg_d = shifted;
        count_d    = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake/status outputs are registered from the next state so they stay glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      zero_q     <= 1'b1;
      shiftReg_q <= '0;
      count_q    <= '0;
      op_q       <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      shiftReg_q <= shiftReg_d;
      count_q    <= count_d;
      op_q       <= op_d;
      inReady_q  <= (state_d == S_IDLE);
      outValid_q <= (state_d == S_DONE);
      busy_q     <= (state_d == S_SHIFT);
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic isShiftOp(input logic [3:0] ctrl);
    return (ctrl == 4'b1001) || (ctrl == 4'b1010) || (ctrl == 4'b1011);
  endfunction

  function automatic logic [31:0] refModel(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (ctrl)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b1000: return a ^ b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: return a << sh;
      4'b1010: return a >> sh;
      4'b1011: return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int refLatency(input logic [3:0] ctrl, input logic [31:0] b);
    if (isShiftOp(ctrl) && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One full transaction: accept, wait out the latency, hold under backpressure, then drain.
  task automatic applyStimulus(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b, input int holdCycles);
    logic [31:0] expRes;
    int          expLat;
    int          lat;
    expRes = refModel(ctrl, a, b);
    expLat = refLatency(ctrl, b);
    @(negedge clk);
    in_valid  = 1'b1;
    alu_ctrl  = ctrl;
    operand_a = a;
    operand_b = b;
    out_ready = 1'b0;
    checkOutput({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    alu_ctrl  = 4'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      checkOutput({tag, " busy_in_shift"}, 32'(busy), 32'd1);
      checkOutput({tag, " in_ready_in_shift"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " zero"}, 32'(zero), 32'(expRes == 32'd0));
    checkOutput({tag, " busy_done"}, 32'(busy), 32'd0);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " hold_result"}, result, expRes);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] opList [10];
    logic [3:0] ctrl;
    opList = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
               4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1111};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = 4'b0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset zero", 32'(zero), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("add_wrap", 4'b0010, 32'h0000_0005, 32'hFFFF_FFFB, 0);
    applyStimulus("sub_neg", 4'b0110, 32'd3, 32'd5, 1);
    applyStimulus("slt_signed", 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus("sra4", 4'b1011, 32'h8000_0000, 32'd4, 0);
    applyStimulus("srl4", 4'b1010, 32'h8000_0000, 32'd4, 0);
    applyStimulus("sll0", 4'b1001, 32'h0000_0001, 32'h0000_0020, 0);
    applyStimulus("sll31", 4'b1001, 32'h0000_0001, 32'd31, 0);
    applyStimulus("xor_bp", 4'b1000, 32'hFF00_FF00, 32'h0F0F_0F0F, 10);
    applyStimulus("illegal", 4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // Reset in the middle of a 20-bit left shift must discard the partial work.
    @(negedge clk);
    in_valid  = 1'b1;
    alu_ctrl  = 4'b1001;
    operand_a = 32'h0000_0001;
    operand_b = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset result", result, 32'd0);
    checkOutput("midreset zero", 32'(zero), 32'd1);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("add_after_reset", 4'b0010, 32'h7FFF_FFFF, 32'd1, 0);

    for (int n = 0; n < 30; n++) begin
      ctrl = opList[$urandom_range(0, 9)];
      applyStimulus($sformatf("rand%0d", n), ctrl, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
